// File: rtl/uart_pkg.sv
// Shared types and constants for the uart core: FSM state encoding and counter widths.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int BIT_CNT_W        = 3;

  // Width of a counter that must hold 0..n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO for the TX path; extra pointer MSB distinguishes full from empty.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_wr, do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign do_wr = wr_en && (!full || do_rd);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart.sv
// Full-duplex UART core (8N1) with TX FIFO. Define UART_PARITY_EN for an even-parity bit
// between data bit 7 and the stop bit on both TX and RX.
module uart
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pc_in_t,
  input  logic       wr_en,
  input  logic       start_tx,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] pc_out_r,
  output logic       rx_done
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  logic [7:0] fifo_dout;
  logic       fifo_full, fifo_empty, fifo_pop;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .rd_en (fifo_pop),
    .din   (pc_in_t),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- transmitter ----------------
  uart_state_t          tx_st, tx_ns;
  logic [CW-1:0]        tx_cnt, tx_cnt_d;
  logic [BIT_CNT_W-1:0] tx_bit, tx_bit_d;
  logic [7:0]           tx_sh, tx_sh_d;
  logic                 tx_d, send_req;
`ifdef UART_PARITY_EN
  logic                 tx_par, tx_par_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st    <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx       <= 1'b1;
      send_req <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_st  <= tx_ns;
      tx_cnt <= tx_cnt_d;
      tx_bit <= tx_bit_d;
      tx_sh  <= tx_sh_d;
      tx     <= tx_d;
`ifdef UART_PARITY_EN
      tx_par <= tx_par_d;
`endif
      // A new request wins over the empty-FIFO clear in the same cycle.
      if (start_tx)                        send_req <= 1'b1;
      else if (tx_st == IDLE && fifo_empty) send_req <= 1'b0;
    end
  end

  always_comb begin
    tx_ns    = tx_st;
    tx_cnt_d = tx_cnt + 1'b1;
    tx_bit_d = tx_bit;
    tx_sh_d  = tx_sh;
    fifo_pop = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d = tx_par;
`endif
    case (tx_st)
      IDLE: begin
        tx_cnt_d = '0;
        if (send_req && !fifo_empty) begin
          fifo_pop = 1'b1;
          tx_sh_d  = fifo_dout;
`ifdef UART_PARITY_EN
          tx_par_d = ^fifo_dout;
`endif
          tx_ns    = START;
        end
      end
      START: if (tx_cnt == BIT_END) begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_ns    = DATA;
      end
      DATA: if (tx_cnt == BIT_END) begin
        tx_cnt_d = '0;
        tx_sh_d  = tx_sh >> 1;
        if (tx_bit == BIT_CNT_W'(7)) begin
`ifdef UART_PARITY_EN
          tx_ns = PARITY;
`else
          tx_ns = STOP;
`endif
        end else begin
          tx_bit_d = tx_bit + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (tx_cnt == BIT_END) begin
        tx_cnt_d = '0;
        tx_ns    = STOP;
      end
`endif
      STOP: if (tx_cnt == BIT_END) begin
        tx_cnt_d = '0;
        tx_ns    = IDLE;
      end
      default: tx_ns = IDLE;
    endcase

    // Line level is registered from the next state so tx is glitch-free.
    case (tx_ns)
      START:   tx_d = 1'b0;
      DATA:    tx_d = tx_sh_d[0];
`ifdef UART_PARITY_EN
      PARITY:  tx_d = tx_par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  uart_state_t          rx_st, rx_ns;
  logic [CW-1:0]        rx_cnt, rx_cnt_d;
  logic [BIT_CNT_W-1:0] rx_bit, rx_bit_d;
  logic [7:0]           rx_sh, rx_sh_d;
  logic                 rx_s1, rx_s2, rx_ferr, rx_ferr_d, done_d;
`ifdef UART_PARITY_EN
  logic                 rx_par_ok, rx_par_ok_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_st    <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_ferr  <= 1'b0;
      rx_done  <= 1'b0;
      pc_out_r <= 8'h00;
`ifdef UART_PARITY_EN
      rx_par_ok <= 1'b0;
`endif
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_st   <= rx_ns;
      rx_cnt  <= rx_cnt_d;
      rx_bit  <= rx_bit_d;
      rx_sh   <= rx_sh_d;
      rx_ferr <= rx_ferr_d;
      rx_done <= done_d;
      if (done_d) pc_out_r <= rx_sh;
`ifdef UART_PARITY_EN
      rx_par_ok <= rx_par_ok_d;
`endif
    end
  end

  always_comb begin
    rx_ns     = rx_st;
    rx_cnt_d  = rx_cnt + 1'b1;
    rx_bit_d  = rx_bit;
    rx_sh_d   = rx_sh;
    rx_ferr_d = rx_ferr;
    done_d    = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_ok_d = rx_par_ok;
`endif
    case (rx_st)
      IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2) rx_ns = START;
      end
      START: if (rx_cnt == HALF_END) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_ns    = rx_s2 ? IDLE : DATA;
      end
      DATA: if (rx_cnt == BIT_END) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2, rx_sh[7:1]};
        if (rx_bit == BIT_CNT_W'(7)) begin
`ifdef UART_PARITY_EN
          rx_ns = PARITY;
`else
          rx_ns = STOP;
`endif
        end else begin
          rx_bit_d = rx_bit + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (rx_cnt == BIT_END) begin
        rx_cnt_d    = '0;
        rx_par_ok_d = ~(^{rx_sh, rx_s2});
        rx_ns       = STOP;
      end
`endif
      STOP: begin
        if (rx_ferr) begin
          // Bad stop bit: hold off until the line returns high.
          rx_cnt_d = '0;
          if (rx_s2) begin
            rx_ferr_d = 1'b0;
            rx_ns     = IDLE;
          end
        end else if (rx_cnt == BIT_END) begin
          rx_cnt_d = '0;
          if (rx_s2) begin
            rx_ns = IDLE;
`ifdef UART_PARITY_EN
            done_d = rx_par_ok;
`else
            done_d = 1'b1;
`endif
          end else begin
            rx_ferr_d = 1'b1;
          end
        end
      end
      default: rx_ns = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart.sv
// Loopback bench for uart: stimulus pushes expected bytes to a queue, an rx_done monitor checks them.
module tb_uart;
  localparam int CF  = 100_000_000;
  localparam int BD  = 6_250_000;   // 16 clocks per bit keeps the run short
  localparam int CPB = CF / BD;

  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] pc_in_t = 8'h00;
  logic       wr_en = 1'b0, start_tx = 1'b0;
  logic       rx_drv = 1'b1, loop = 1'b1;
  logic       rx, tx, rx_done;
  logic [7:0] pc_out_r;

  assign rx = loop ? tx : rx_drv;
  always #5 clk = ~clk;

  uart #(.CLK_FREQ(CF), .BAUD(BD), .FIFO_DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc_in_t  (pc_in_t),
    .wr_en    (wr_en),
    .start_tx (start_tx),
    .rx       (rx),
    .tx       (tx),
    .pc_out_r (pc_out_r),
    .rx_done  (rx_done)
  );

  int         checks = 0, errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rx_done must match the oldest outstanding expected byte.
  always @(negedge clk) begin
    if (!rst && rx_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %02h expected no rx_done", pc_out_r);
      end else begin
        check("rx_byte", int'(pc_out_r), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the following negedge.
  task automatic push(input logic [7:0] b, input logic s);
    pc_in_t = b; wr_en = 1'b1; start_tx = s;
    @(negedge clk);
    wr_en = 1'b0; start_tx = 1'b0;
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (20) @(negedge clk);
  endtask

  task automatic serial(input logic [7:0] b, input logic stop_b);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = stop_b;
    repeat (CPB) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin
    logic [9:0] frame;
    int n, lows;

    repeat (2) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_rx_done", rx_done, 0);
    check("reset_pc_out", pc_out_r, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single byte, frame shape and start-bit latency
    exp_q.push_back(8'hA5);
    push(8'hA5, 1'b1);
    check("t1_tx_idle_cycle1", tx, 1);
    @(negedge clk);
    check("t1_start_latency", tx, 0);
    frame = {1'b1, 8'hA5, 1'b0};
    repeat (CPB / 2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t1_frame_bit%0d", k), tx, frame[k]);
      if (k < 9) repeat (CPB) @(negedge clk);
    end
    drain("t1_drain", 400);

    // 2: second byte, previous byte held until replaced
    check("t2_hold_before", pc_out_r, 8'hA5);
    exp_q.push_back(8'h3C);
    push(8'h3C, 1'b1);
    repeat (100) @(negedge clk);
    check("t2_hold_during", pc_out_r, 8'hA5);
    drain("t2_drain", 400);

    // 3: burst, back-to-back frames
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(8'(i));
      push(8'(i), 1'b0);
    end
    start_tx = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      start_tx = 1'b0;
      n++;
    end
    checks++;
    if (n < 470 || n > 490) begin
      errors++;
      $display("FAIL t3_back_to_back: got %0d cycles expected 470..490", n);
    end
    drain("t3_drain", 10);

    // 4: overflow, 17th byte dropped
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      push(8'(i), 1'b0);
    end
    push(8'h00, 1'b0);
    start_tx = 1'b1; @(negedge clk); start_tx = 1'b0;
    drain("t4_drain", 3000);
    repeat (400) @(negedge clk);

    // 5: glitch and framing error from a bench-driven line, then a good frame
    loop = 1'b0;
    rx_drv = 1'b0; repeat (5) @(negedge clk); rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rx_drv = 1'b0; @(negedge clk); rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    serial(8'h96, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("t5_no_done_after_errors", pc_out_r, 8'h0F);
    exp_q.push_back(8'hC3);
    serial(8'hC3, 1'b1);
    drain("t5_drain", 200);
    loop = 1'b1;

    // 6: reset during DATA
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b1);
    repeat (60) @(negedge clk);
    check("t6_tx_in_data", tx, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_tx_after_rst", tx, 1);
    check("t6_rx_done_after_rst", rx_done, 0);
    check("t6_pc_out_after_rst", pc_out_r, 0);
    rst = 1'b0;
    start_tx = 1'b1; @(negedge clk); start_tx = 1'b0;
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    check("t6_fifo_empty_tx_low_cycles", lows, 0);
    exp_q.push_back(8'h5A);
    push(8'h5A, 1'b1);
    drain("t6_drain", 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
